python_frame_rx: RTL and testbench
==================================

Name: python_frame_rx

Overview:
- Receive-side framer for the 8-bit Python sensor pixel stream (data/fv/lv) on the sensor clock.
- Sits directly downstream of the sensor interface and upstream of the corner detector core.
- Registers the raw stream, tracks frame/line state, strips black rows, and emits a qualified pixel stream with coordinates and SOF/EOL/EOF markers.
- Flags geometry and protocol violations.

Parameters:
- COLS, 16, expected active pixels per line (lv high cycles per row).
- ROWS, 8, expected rows per frame, including black rows.
- BLACK_ROWS, 3, leading rows of each frame counted but not forwarded; must be < ROWS.

Ports:
- c  input  1  pixel clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  sensor pixel word.
- in_fv  input  1  frame valid.
- in_lv  input  1  line valid.
- out_data  output  8  forwarded pixel.
- out_valid  output  1  out_data qualifies this cycle.
- out_sof  output  1  first forwarded pixel of frame (x=0, y=0).
- out_eol  output  1  pixel with x=COLS-1.
- out_eof  output  1  pixel with x=COLS-1 and y=ROWS-BLACK_ROWS-1.
- out_x  output  $clog2(COLS)  column of out_data.
- out_y  output  $clog2(ROWS)  active row of out_data (0 = first non-black row).
- line_err  output  1  one-cycle pulse: a line ended with length != COLS.
- frame_err  output  1  one-cycle pulse: a frame ended with row count != ROWS.
- proto_err  output  1  one-cycle pulse: lv high while fv low.
- frame_cnt  output  16  completed frames (FRAME_STATS_EN).
- last_line_len  output  16  length of most recent line (FRAME_STATS_EN).

Behaviour:
- Reset: all outputs 0; state SYNC; counters 0. Reset asserted mid-frame discards the frame; the block returns to SYNC.
- Input stage: in_data/in_fv/in_lv registered once (fv_r, lv_r, d_r). Output stage registered. Fixed latency from input sample to out_* is 2 cycles.
- States:
  - SYNC: ignore all input until fv_r=0, then go to IDLE. This prevents output of a partial frame after reset.
  - IDLE: on fv_r rising, clear row and col, go to FRAME.
  - FRAME: on lv_r rising, go to LINE. On fv_r falling, run the frame-end check and go to IDLE.
  - LINE: each cycle with lv_r=1, col++ (saturating at 2^16-1). On lv_r falling, run the line-end check, row++, and go to FRAME. If fv_r and lv_r fall together, run the line-end check, then the frame-end check, then go to IDLE.
- Forwarding: a pixel is forwarded (out_valid=1) only when state is LINE, lv_r=1, row >= BLACK_ROWS, row < ROWS, and col < COLS.
  - out_x = col; out_y = row - BLACK_ROWS.
  - Excess pixels and excess rows are dropped silently.
- Markers are derived from the expected geometry only; they may coincide on one pixel. With ROWS-BLACK_ROWS=1 and COLS=1, sof, eol and eof all assert together.
- Line-end check: col != COLS gives line_err=1 for one cycle, on the cycle after lv_r falls. Black rows are also checked.
- Frame-end check: row != ROWS gives frame_err=1 for one cycle. A line-end error and a frame-end error on the same edge both pulse in the same cycle.
- proto_err pulses each cycle lv_r=1 while fv_r=0, in any state except SYNC. No state change results.
- Counter widths: row and col are 16-bit internally; comparisons are done at 16 bits.

Optional Feature:
- Macro: PYTHON_FRAME_RX_STATS_EN.
- Defined:
  - frame_cnt increments (wrapping at 16 bits) at each frame-end from FRAME/LINE, regardless of frame_err.
  - last_line_len loads the col count at each line-end.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset mid-line, then release with fv=1 → no out_valid until fv drops and a fresh frame starts; all outputs 0 during reset.
- Nominal frame COLS=16, ROWS=8, BLACK_ROWS=3, pixels = ramp 0..127 → 80 out_valid cycles.
  - First forwarded pixel is 48 with sof; eol on x=15; eof only on data 127 (y=4).
  - No errors. Each output appears 2 cycles after its input.
- Line of 17 pixels in row 4 → pixel 17 not forwarded; line_err pulses once after lv falls; last_line_len=17 with the STATS macro.
- Frame of 7 rows, then fv drops → frame_err pulse, no eof; next frame is nominal and has no errors.
- lv held high 3 cycles while fv=0 between frames → proto_err high 3 cycles; no out_valid; frame_cnt unchanged.
- fv and lv fall together after 10 pixels on row 7 → line_err and frame_err pulse in the same cycle; state returns to IDLE; the next frame's sof is correct.

Source files
------------

// File: rtl/python_frame_rx.sv
// Receive-side framer for the 8-bit Python sensor stream (data/fv/lv).
// Latency: fixed 2 cycles from input sample to any out_* / *_err pulse.
// Backpressure: none; the sensor cannot be stalled, every cycle is consumed.
//
// Ports:
//   c, rst_n                     pixel clock, async active-low reset
//   in_data/in_fv/in_lv          raw sensor stream
//   out_data/out_valid           qualified pixel (black rows, excess pixels/rows dropped)
//   out_sof/out_eol/out_eof      geometry markers, out_x/out_y pixel coordinates
//   line_err/frame_err/proto_err one-cycle violation pulses
//   frame_cnt/last_line_len      statistics, live only when PYTHON_FRAME_RX_STATS_EN
//                                is defined, otherwise tied to 0
module python_frame_rx #(
  parameter int COLS       = 16,
  parameter int ROWS       = 8,
  parameter int BLACK_ROWS = 3
) (
  input  logic                      c,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_fv,
  input  logic                      in_lv,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic [$clog2(COLS)-1:0]   out_x,
  output logic [$clog2(ROWS)-1:0]   out_y,
  output logic                      line_err,
  output logic                      frame_err,
  output logic                      proto_err,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               last_line_len
);

  localparam int          XW      = $clog2(COLS);
  localparam int          YW      = $clog2(ROWS);
  localparam logic [15:0] COLS16  = 16'(COLS);
  localparam logic [15:0] ROWS16  = 16'(ROWS);
  localparam logic [15:0] BLACK16 = 16'(BLACK_ROWS);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2,
    S_LINE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        fv_q, lv_q;
  logic [7:0]  d_q;
  // Set once the input register holds a real post-reset sample; without it
  // the reset value fv_q=0 would let SYNC exit in the middle of a frame.
  logic        in_vld_q;
  logic [15:0] row_q, col_q;

  // Input stage
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      fv_q     <= 1'b0;
      lv_q     <= 1'b0;
      d_q      <= 8'd0;
      in_vld_q <= 1'b0;
    end else begin
      fv_q     <= in_fv;
      lv_q     <= in_lv;
      d_q      <= in_data;
      in_vld_q <= 1'b1;
    end
  end

  logic        in_frame, pix_take, fwd, line_end, frame_end;
  logic [15:0] col_inc, row_inc;

  assign in_frame  = (state_q == S_FRAME) || (state_q == S_LINE);
  // fv dropping ends the frame in FRAME or LINE; in LINE it also closes the
  // current line, whether or not lv dropped on the same sample.
  assign frame_end = in_frame && !fv_q;
  assign line_end  = (state_q == S_LINE) && (!fv_q || !lv_q);
  // The lv rising sample is seen in FRAME and is already the pixel at col 0.
  assign pix_take  = in_frame && fv_q && lv_q;
  assign fwd       = pix_take && (row_q >= BLACK16) && (row_q < ROWS16) &&
                     (col_q < COLS16);
  assign col_inc   = (col_q == 16'hFFFF) ? col_q : col_q + 16'd1;
  assign row_inc   = (row_q == 16'hFFFF) ? row_q : row_q + 16'd1;

  // Frame/line FSM with registered output stage
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SYNC;
      row_q     <= 16'd0;
      col_q     <= 16'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      proto_err <= (state_q != S_SYNC) && lv_q && !fv_q;

      // data/x/y hold their last value between valid pixels
      if (fwd) begin
        out_valid <= 1'b1;
        out_data  <= d_q;
        out_x     <= XW'(col_q);
        out_y     <= YW'(row_q - BLACK16);
        out_sof   <= (col_q == 16'd0) && (row_q == BLACK16);
        out_eol   <= (col_q == COLS16 - 16'd1);
        out_eof   <= (col_q == COLS16 - 16'd1) && (row_q == ROWS16 - 16'd1);
      end

      case (state_q)
        S_SYNC: begin
          if (in_vld_q && !fv_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (fv_q) begin
            row_q   <= 16'd0;
            col_q   <= 16'd0;
            state_q <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (frame_end) begin
            frame_err <= (row_q != ROWS16);
            state_q   <= S_IDLE;
          end else if (lv_q) begin
            col_q   <= col_inc;
            state_q <= S_LINE;
          end
        end
        S_LINE: begin
          if (frame_end) begin
            // Truncated last line: row is not advanced before the frame check.
            line_err  <= (col_q != COLS16);
            frame_err <= (row_q != ROWS16);
            col_q     <= 16'd0;
            state_q   <= S_IDLE;
          end else if (line_end) begin
            line_err <= (col_q != COLS16);
            row_q    <= row_inc;
            col_q    <= 16'd0;
            state_q  <= S_FRAME;
          end else begin
            col_q <= col_inc;
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

`ifdef PYTHON_FRAME_RX_STATS_EN
  logic [15:0] frame_cnt_q, last_line_len_q;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q     <= 16'd0;
      last_line_len_q <= 16'd0;
    end else begin
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (line_end)  last_line_len_q <= col_q;
    end
  end

  assign frame_cnt     = frame_cnt_q;
  assign last_line_len = last_line_len_q;
`else
  assign frame_cnt     = 16'd0;
  assign last_line_len = 16'd0;
`endif

endmodule

// File: tb/tb_python_frame_rx.sv
module tb_python_frame_rx;

  localparam int COLS  = 16;
  localparam int ROWS  = 8;
  localparam int BLACK = 3;

  logic       c;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_fv, in_lv;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eol, out_eof;
  logic [3:0] out_x;
  logic [2:0] out_y;
  logic       line_err, frame_err, proto_err;
  logic [15:0] frame_cnt, last_line_len;

  python_frame_rx #(.COLS(COLS), .ROWS(ROWS), .BLACK_ROWS(BLACK)) dut (
    .c(c), .rst_n(rst_n), .in_data(in_data), .in_fv(in_fv), .in_lv(in_lv),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eol(out_eol), .out_eof(out_eof), .out_x(out_x), .out_y(out_y),
    .line_err(line_err), .frame_err(frame_err), .proto_err(proto_err),
    .frame_cnt(frame_cnt), .last_line_len(last_line_len)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // Expected outputs caused by one input sample (seen two edges later).
  typedef struct {
    logic       v;
    logic [7:0] d;
    int         x;
    int         y;
    logic       le;
    logic       fe;
    logic       pe;
    int         fc;
    int         ll;
  } exp_t;

  exp_t pend;
  bit   armed;      // model: a clean frame boundary has been seen since reset
  int   m_fcnt, m_llen;
  int   ncmp, nfail, nvalid;
  int   lens[16];

  function automatic exp_t blank();
    exp_t e;
    e.v = 1'b0; e.d = 8'd0; e.x = 0; e.y = 0;
    e.le = 1'b0; e.fe = 1'b0; e.pe = 1'b0; e.fc = 0; e.ll = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One input sample; checks the outputs produced by the previous sample.
  task automatic step(input logic fv, input logic lv, input logic [7:0] d, input exp_t e_in);
    exp_t e;
    logic want_eol;
    e = e_in;
    in_fv = fv; in_lv = lv; in_data = d;
    if (!rst_n) begin
      armed = 1'b0; m_fcnt = 0; m_llen = 0;
      pend = blank();
      e = blank();
    end
    e.fc = m_fcnt;
    e.ll = m_llen;
    @(posedge c); #1;
    want_eol = pend.v && (pend.x == COLS - 1);
    chk("valid", 32'(out_valid), 32'(pend.v));
    if (pend.v) begin
      chk("data", 32'(out_data), 32'(pend.d));
      chk("x", 32'(out_x), pend.x);
      chk("y", 32'(out_y), pend.y);
    end
    chk("sof", 32'(out_sof), 32'(pend.v && pend.x == 0 && pend.y == 0));
    chk("eol", 32'(out_eol), 32'(want_eol));
    chk("eof", 32'(out_eof), 32'(want_eol && pend.y == ROWS - BLACK - 1));
    chk("line_err", 32'(line_err), 32'(pend.le));
    chk("frame_err", 32'(frame_err), 32'(pend.fe));
    chk("proto_err", 32'(proto_err), 32'(pend.pe));
`ifdef PYTHON_FRAME_RX_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), pend.fc);
    chk("last_line_len", 32'(last_line_len), pend.ll);
`else
    chk("frame_cnt", 32'(frame_cnt), 0);
    chk("last_line_len", 32'(last_line_len), 0);
`endif
    nvalid += int'(out_valid);
    pend = e;
    if (rst_n && !fv) armed = 1'b1;
  endtask

  // A frame described by its row count and lens[]; expected outputs follow
  // from the frame geometry. rst_row >= 0 pulses reset 5 pixels into that row.
  task automatic send_frame(input int nrows, input bit ramp, input bit abort_last, input int rst_row);
    exp_t e;
    logic [7:0] d;
    step(1'b1, 1'b0, 8'd0, blank());
    step(1'b1, 1'b0, 8'd0, blank());
    for (int r = 0; r < nrows; r++) begin
      for (int x = 0; x < lens[r]; x++) begin
        if (r == rst_row && x == 5) begin
          rst_n = 1'b0;
          for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'($urandom), blank());
          rst_n = 1'b1;
        end
        d = ramp ? 8'(r * COLS + x) : 8'($urandom);
        e = blank();
        e.v = armed && r >= BLACK && r < ROWS && x < COLS;
        e.d = d; e.x = x; e.y = r - BLACK;
        step(1'b1, 1'b1, d, e);
      end
      if (!(abort_last && r == nrows - 1)) begin
        e = blank();
        if (armed) begin
          e.le = (lens[r] != COLS);
          m_llen = lens[r];
        end
        step(1'b1, 1'b0, 8'd0, e);
        step(1'b1, 1'b0, 8'd0, blank());
      end
    end
    e = blank();
    if (armed) begin
      if (abort_last) begin
        e.le = (lens[nrows-1] != COLS);
        m_llen = lens[nrows-1];
        e.fe = ((nrows - 1) != ROWS);
      end else begin
        e.fe = (nrows != ROWS);
      end
      m_fcnt = (m_fcnt + 1) & 32'hFFFF;
    end
    step(1'b0, 1'b0, 8'd0, e);
    step(1'b0, 1'b0, 8'd0, blank());
    step(1'b0, 1'b0, 8'd0, blank());
  endtask

  task automatic nominal_lens();
    for (int i = 0; i < 16; i++) lens[i] = COLS;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    ncmp = 0; nfail = 0; nvalid = 0;
    armed = 1'b0; m_fcnt = 0; m_llen = 0;
    pend = blank();
    rst_n = 1'b1; in_fv = 1'b0; in_lv = 1'b0; in_data = 8'd0;
    nominal_lens();
    #2 rst_n = 1'b0;

    // Reset state, then reset pulsed mid-line and released with fv high.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'd0, blank());
    rst_n = 1'b1;
    nvalid = 0;
    send_frame(8, 1'b0, 1'b0, 1);
    chk("sync_no_valid", nvalid, 0);

    // Nominal ramp frame: pixels 48..127 forwarded.
    nvalid = 0;
    send_frame(8, 1'b1, 1'b0, -1);
    chk("nominal_valid_count", nvalid, 80);

    // Over-long line in row 4.
    lens[4] = 17;
    send_frame(8, 1'b0, 1'b0, -1);
    nominal_lens();

    // Short frame, then a clean one.
    send_frame(7, 1'b0, 1'b0, -1);
    send_frame(8, 1'b1, 1'b0, -1);

    // lv high while fv low between frames.
    nvalid = 0;
    for (int k = 0; k < 3; k++) begin
      e = blank();
      e.pe = armed;
      step(1'b0, 1'b1, 8'($urandom), e);
    end
    step(1'b0, 1'b0, 8'd0, blank());
    step(1'b0, 1'b0, 8'd0, blank());
    chk("proto_no_valid", nvalid, 0);

    // fv and lv fall together 10 pixels into row 7, then a normal frame.
    lens[7] = 10;
    send_frame(8, 1'b0, 1'b1, -1);
    nominal_lens();
    send_frame(8, 1'b1, 1'b0, -1);

    // Reset in the middle of an armed frame, recovery on the next one.
    send_frame(8, 1'b0, 1'b0, 5);
    send_frame(8, 1'b0, 1'b0, -1);

    // Random geometry: line lengths COLS-1..COLS+1, 6..9 rows.
    for (int f = 0; f < 6; f++) begin
      int nr;
      nr = $urandom_range(6, 9);
      for (int i = 0; i < 16; i++) lens[i] = COLS - 1 + $urandom_range(0, 2);
      send_frame(nr, 1'b0, 1'b0, -1);
    end
    nominal_lens();
    send_frame(8, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
